// File: rtl/dtpu_infifo_if.sv
// Stream-in and core-side handshake bundle for the input FIFO.
// The FIFO takes the slave view; the DMA/core side takes the master view.
interface dtpu_infifo_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] infifo_dout;
    logic                  infifo_last;
    logic                  infifo_is_empty;
    logic                  infifo_read;

    modport slave (
        input  s_axis_tdata,
        input  s_axis_tvalid,
        input  s_axis_tlast,
        input  infifo_read,
        output s_axis_tready,
        output infifo_dout,
        output infifo_last,
        output infifo_is_empty
    );

    modport master (
        output s_axis_tdata,
        output s_axis_tvalid,
        output s_axis_tlast,
        output infifo_read,
        input  s_axis_tready,
        input  infifo_dout,
        input  infifo_last,
        input  infifo_is_empty
    );
endinterface

// File: rtl/dtpu_infifo.sv
// First-word-fall-through input FIFO between the AXI-Stream DMA channel and dtpu_core,
// with fill level and sticky underflow / tlast flags for the CSR bank.
module dtpu_infifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    dtpu_infifo_if.slave     bus,
    input  logic             err_clear,
    output logic [CNT_W-1:0] fill_count,
    output logic             underflow_err,
    output logic             tlast_seen
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PTR_W-1:0]    wptr;
    logic [PTR_W-1:0]    rptr;
    logic [DATA_WIDTH:0] head;
    logic                empty;
    logic                ready;
    logic                push;
    logic                pop;
    logic                read_empty;

    // tready drops during reset/clear so a beat offered then is never considered taken.
    assign ready      = (fill_count != FULL) & ~reset & ~clear;
    assign empty      = (fill_count == '0);
    assign push       = bus.s_axis_tvalid & ready;
    assign pop        = bus.infifo_read & ~empty;
    assign read_empty = bus.infifo_read & empty;
    assign head       = mem[rptr];

    assign bus.s_axis_tready   = ready;
    assign bus.infifo_is_empty = empty;
    assign bus.infifo_dout     = empty ? '0 : head[DATA_WIDTH-1:0];
    assign bus.infifo_last     = empty ? 1'b0 : head[DATA_WIDTH];

    // Storage has no reset; entries are only observable through a valid pointer range.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {bus.s_axis_tlast, bus.s_axis_tdata};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr          <= '0;
            rptr          <= '0;
            fill_count    <= '0;
            underflow_err <= 1'b0;
            tlast_seen    <= 1'b0;
        end else if (clear) begin
            wptr       <= '0;
            rptr       <= '0;
            fill_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                fill_count <= fill_count + 1'b1;
            end else if (pop && !push) begin
                fill_count <= fill_count - 1'b1;
            end
            // A setting event in the same cycle as err_clear wins.
            if (read_empty) begin
                underflow_err <= 1'b1;
            end else if (err_clear) begin
                underflow_err <= 1'b0;
            end
            if (push && bus.s_axis_tlast) begin
                tlast_seen <= 1'b1;
            end else if (err_clear) begin
                tlast_seen <= 1'b0;
            end
        end
    end
endmodule
